// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_LOAD
    } fetch_state_e;

    // Width of the WAIT-cycle timeout counter (TIMEOUT range 1..255)
    localparam int unsigned CNT_W      = 8;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 16;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: fetch unit is master, memory is slave.
interface instr_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rd;
    logic              imem_valid;
    logic [DATA_W-1:0] imem_data;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_valid,
        output imem_data
    );

endinterface

// File: rtl/fetch_pc.sv
// Program counter with increment, direct load, pending-redirect latch and wrap.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              busy_i,      // a fetch is in flight
    input  logic              load_i,      // redirect strobe
    input  logic [ADDR_W-1:0] load_val_i,  // redirect target
    input  logic              commit_i,    // fetch completing (LOAD)
    input  logic              abort_i,     // fetch abandoned on timeout
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              redir;
    logic [ADDR_W-1:0] target;

    // A redirect arriving in the very cycle the fetch resolves is the newest one
    assign redir  = load_i | pend_vld_q;
    assign target = load_i ? load_val_i : pend_q;

    // Next PC / pending-redirect selection
    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (!busy_i) begin
            if (load_i) begin
                pc_d = load_val_i;
            end
        end else if (commit_i) begin
            pc_d       = redir ? target : pc_q + ADDR_W'(1);
            pend_vld_d = 1'b0;
        end else if (abort_i) begin
            if (redir) begin
                pc_d = target;
            end
            pend_vld_d = 1'b0;
        end else if (load_i) begin
            pend_d     = load_val_i;
            pend_vld_d = 1'b1;
        end
    end

    // PC and pending-redirect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-side master: issues single-word instruction reads and hands the
// returned word to the instruction register with a one-cycle write strobe.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_start,
    input  logic                pc_load,
    input  logic [ADDR_W-1:0]   pc_load_val,
    instr_fetch_unit_if.master  imem,
    output logic [DATA_W-1:0]   ir_data,
    output logic                ir_we,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                fetch_done,
    output logic                fetch_err
);

    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [DATA_W-1:0] ir_data_q, ir_data_d;
    logic              ir_we_q, ir_we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              commit, abort;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and registered-output selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rd_d      = 1'b0;
        ir_data_d = ir_data_q;
        ir_we_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        commit    = 1'b0;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_start) begin
                    state_d = ST_REQ;
                    rd_d    = 1'b1;
                    addr_d  = pc_load ? pc_load_val : pc;
                    err_d   = 1'b0;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (imem.imem_valid) begin
                    ir_data_d = imem.imem_data;
                    ir_we_d   = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_LOAD;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        abort   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOAD: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= RESET_PC;
            rd_q      <= 1'b0;
            ir_data_q <= '0;
            ir_we_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            ir_data_q <= ir_data_d;
            ir_we_q   <= ir_we_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .busy_i     (state_q != ST_IDLE),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .commit_i   (commit),
        .abort_i    (abort),
        .pc_o       (pc)
    );

    assign imem.imem_addr = addr_q;
    assign imem.imem_rd   = rd_q;
    assign ir_data        = ir_data_q;
    assign ir_we          = ir_we_q;
    assign fetch_done     = done_q;
    assign fetch_err      = err_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [7:0]  pc_load_val = '0;
    logic [15:0] ir_data;
    logic        ir_we;
    logic [7:0]  pc;
    logic        busy;
    logic        fetch_done;
    logic        fetch_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .RESET_PC (8'h00),
        .TIMEOUT  (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .imem        (bus),
        .ir_data     (ir_data),
        .ir_we       (ir_we),
        .pc          (pc),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pc"},       32'(pc), 32'h00);
        check({tag, " addr"},     32'(bus.imem_addr), 32'h00);
        check({tag, " ir_data"},  32'(ir_data), 32'h0);
        check({tag, " rd"},       32'(bus.imem_rd), 32'h0);
        check({tag, " ir_we"},    32'(ir_we), 32'h0);
        check({tag, " done"},     32'(fetch_done), 32'h0);
        check({tag, " busy"},     32'(busy), 32'h0);
        check({tag, " err"},      32'(fetch_err), 32'h0);
    endtask

    // Caller has set fetch_start (and optionally pc_load) for cycle 0.
    task automatic run_fetch(input string tag, input logic [15:0] data,
                             input logic [7:0] exp_addr, input logic [7:0] exp_pc);
        tick();                               // cycle 1: REQ
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        check({tag, " rd"},   32'(bus.imem_rd), 32'h1);
        check({tag, " addr"}, 32'(bus.imem_addr), 32'(exp_addr));
        check({tag, " busy"}, 32'(busy), 32'h1);
        tick();                               // cycle 2: WAIT, memory answers
        check({tag, " rd one cycle"}, 32'(bus.imem_rd), 32'h0);
        bus.imem_valid = 1'b1;
        bus.imem_data  = data;
        tick();                               // cycle 3: LOAD
        bus.imem_valid = 1'b0;
        check({tag, " ir_we"},   32'(ir_we), 32'h1);
        check({tag, " done"},    32'(fetch_done), 32'h1);
        check({tag, " ir_data"}, 32'(ir_data), 32'(data));
        tick();                               // cycle 4: IDLE, new PC
        check({tag, " pc"},        32'(pc), 32'(exp_pc));
        check({tag, " ir_we off"}, 32'(ir_we), 32'h0);
        check({tag, " idle"},      32'(busy), 32'h0);
        check({tag, " ir hold"},   32'(ir_data), 32'(data));
    endtask

    int unsigned n;
    logic        we_seen;

    initial begin
        bus.imem_valid = 1'b0;
        bus.imem_data  = '0;
        #1;
        check_reset_vals("reset");
        tick();
        tick();
        rst = 1'b0;

        // Basic fetch from RESET_PC
        fetch_start = 1'b1;
        run_fetch("basic", 16'h1234, 8'h00, 8'h01);

        // Redirect in IDLE, then fetch
        pc_load = 1'b1; pc_load_val = 8'h40;
        tick();
        pc_load = 1'b0;
        check("idle load pc", 32'(pc), 32'h40);
        fetch_start = 1'b1;
        run_fetch("load then fetch", 16'h1111, 8'h40, 8'h41);

        // Redirect and fetch in the same cycle
        pc_load = 1'b1; pc_load_val = 8'h40; fetch_start = 1'b1;
        run_fetch("load+fetch", 16'h2222, 8'h40, 8'h41);

        // Two redirects during WAIT; latest wins at LOAD
        fetch_start = 1'b1;
        tick();                               // REQ
        fetch_start = 1'b0;
        check("pend addr", 32'(bus.imem_addr), 32'h41);
        tick();                               // WAIT
        pc_load = 1'b1; pc_load_val = 8'h10;
        tick();                               // WAIT
        pc_load_val = 8'h20;
        tick();                               // WAIT
        pc_load = 1'b0;
        check("pend pc held", 32'(pc), 32'h41);
        bus.imem_valid = 1'b1; bus.imem_data = 16'hBEEF;
        tick();                               // LOAD
        bus.imem_valid = 1'b0;
        check("pend ir_we", 32'(ir_we), 32'h1);
        check("pend ir_data", 32'(ir_data), 32'hBEEF);
        tick();
        check("pend pc", 32'(pc), 32'h20);

        // Timeout: no response for 15 WAIT cycles
        fetch_start = 1'b1;
        tick();                               // REQ
        fetch_start = 1'b0;
        tick();                               // first WAIT
        n = 0; we_seen = 1'b0;
        while (busy && n < 40) begin
            if (ir_we) we_seen = 1'b1;
            tick();
            n++;
        end
        check("to wait cycles", n, 15);
        check("to err", 32'(fetch_err), 32'h1);
        check("to pc", 32'(pc), 32'h20);
        check("to no ir_we", 32'(we_seen), 32'h0);
        bus.imem_valid = 1'b1; bus.imem_data = 16'hDEAD;
        tick();
        bus.imem_valid = 1'b0;
        tick();
        check("late valid ir_we", 32'(ir_we), 32'h0);
        check("late valid busy", 32'(busy), 32'h0);
        check("late valid ir_data", 32'(ir_data), 32'hBEEF);

        // Second timeout with a redirect pending: redirect applied on abort
        fetch_start = 1'b1;
        tick();                               // REQ
        fetch_start = 1'b0;
        check("err cleared", 32'(fetch_err), 32'h0);
        tick();                               // first WAIT
        pc_load = 1'b1; pc_load_val = 8'h80;
        tick();
        pc_load = 1'b0;
        n = 1;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("to2 wait cycles", n, 15);
        check("to2 err", 32'(fetch_err), 32'h1);
        check("to2 pc", 32'(pc), 32'h80);

        // Wrap from all-ones
        pc_load = 1'b1; pc_load_val = 8'hFF;
        tick();
        pc_load = 1'b0;
        fetch_start = 1'b1;
        run_fetch("wrap", 16'h5A5A, 8'hFF, 8'h00);
        check("wrap err cleared", 32'(fetch_err), 32'h0);

        // Reset during WAIT, then a stale response
        pc_load = 1'b1; pc_load_val = 8'h33;
        tick();
        pc_load = 1'b0;
        fetch_start = 1'b1;
        tick();                               // REQ
        fetch_start = 1'b0;
        tick();                               // WAIT
        rst = 1'b1;
        #1;
        check_reset_vals("mid reset");
        tick();
        rst = 1'b0;
        bus.imem_valid = 1'b1; bus.imem_data = 16'h7777;
        tick();
        bus.imem_valid = 1'b0;
        check("post reset ir_we", 32'(ir_we), 32'h0);
        tick();
        check("post reset ir_we2", 32'(ir_we), 32'h0);
        check("post reset ir_data", 32'(ir_data), 32'h0);
        check("post reset pc", 32'(pc), 32'h00);
        check("post reset busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
